// File: rtl/mem_indirect_seq.sv
// mem_indirect_seq: LC-3b MEM-stage D-cache sequencer with LDI/STI pointer-then-data phases and byte lanes.
// Ports:
//   iClk, iRstN                     clock, asynchronous active-low reset
//   iMemRead/iMemWrite              MEM-stage load / store
//   iIndirect, iByte                LDI/STI and LDB/STB qualifiers
//   iAddr, iWData                   effective address and store data
//   iAdvance, iFlush                pipeline hand-off and squash
//   oDCacheRead/Write/Addr/WData/ByteEn, iDCacheRData, iDCacheResp   D-cache request/response
//   oIstate                         0 = pointer phase or non-indirect, 1 = data phase
//   oRData                          load result (byte loads zero-extended)
//   oIndirectCount, oWaitCycles     statistics, built only with MEM_INDIRECT_STATS_EN defined
module mem_indirect_seq (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iIndirect,
    input  logic        iByte,
    input  logic [15:0] iAddr,
    input  logic [15:0] iWData,
    input  logic        iAdvance,
    input  logic        iFlush,
    output logic        oDCacheRead,
    output logic        oDCacheWrite,
    output logic [15:0] oDCacheAddr,
    output logic [15:0] oDCacheWData,
    output logic [1:0]  oDCacheByteEn,
    input  logic [15:0] iDCacheRData,
    input  logic        iDCacheResp,
    output logic        oIstate,
    output logic [15:0] oRData,
    output logic [31:0] oIndirectCount,
    output logic [31:0] oWaitCycles
);
    typedef enum logic {PHASE0, PHASE1} phase_e;
    phase_e      state_q, state_d;
    logic [15:1] ptr_q, ptr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        held_q, held_d;
    logic        act, p1, rd, wr, resp_v, done1;
    logic [15:0] addr, wdata, word, waddr;
    logic [1:0]  be;
    always_comb begin
        act    = iMemRead | iMemWrite;
        p1     = state_q == PHASE1;
        waddr  = {iAddr[15:1], 1'b0};
        // A held data-phase response suppresses re-issue until the pipeline advances
        rd     = p1 ? iMemRead & ~held_q : (iIndirect ? act : iMemRead);
        wr     = p1 ? iMemWrite & ~held_q : (~iIndirect & iMemWrite);
        addr   = p1 ? {ptr_q, 1'b0} : ((iByte & ~iIndirect) ? iAddr : waddr);
        be     = (p1 | iIndirect | ~iByte) ? 2'b11 : (iAddr[0] ? 2'b10 : 2'b01);
        wdata  = (p1 | iIndirect | ~iByte) ? iWData : {iWData[7:0], iWData[7:0]};
        resp_v = iDCacheResp & (rd | wr);
        word   = resp_v ? iDCacheRData : rdata_q;
        done1  = p1 & (resp_v | held_q) & iAdvance;
        state_d = iFlush ? PHASE0 :
                  p1     ? (done1 ? PHASE0 : PHASE1) :
                  (iIndirect & resp_v) ? PHASE1 : PHASE0;
        ptr_d   = (~p1 & iIndirect & resp_v & ~iFlush) ? iDCacheRData[15:1] : ptr_q;
        held_d  = ~iFlush & p1 & ~iAdvance & (held_q | resp_v);
        rdata_d = resp_v ? iDCacheRData : rdata_q;
    end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= PHASE0;
            ptr_q   <= '0;
            rdata_q <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            held_q  <= held_d;
        end
    end
    // Outputs are forced low while reset is asserted so an abandoned request drops at once
    assign oDCacheRead   = iRstN & rd;
    assign oDCacheWrite  = iRstN & wr;
    assign oDCacheAddr   = iRstN ? addr : '0;
    assign oDCacheWData  = iRstN ? wdata : '0;
    assign oDCacheByteEn = iRstN ? be : '0;
    assign oIstate       = iRstN & p1;
    assign oRData        = ~iRstN ? '0 : (iByte ? {8'h00, iAddr[0] ? word[15:8] : word[7:0]} : word);
`ifdef MEM_INDIRECT_STATS_EN
    logic [31:0] icnt_q, icnt_d, wcnt_q, wcnt_d;
    always_comb begin
        icnt_d = icnt_q + {31'b0, done1 & ~iFlush};
        wcnt_d = wcnt_q + {31'b0, (rd | wr) & ~iDCacheResp & ~iFlush};
    end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            icnt_q <= '0;
            wcnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
            wcnt_q <= wcnt_d;
        end
    end
    assign oIndirectCount = icnt_q;
    assign oWaitCycles    = wcnt_q;
`else
    assign oIndirectCount = '0;
    assign oWaitCycles    = '0;
`endif
endmodule

// File: tb/tb_mem_indirect_seq.sv
// tb_mem_indirect_seq: randomized and directed checks of mem_indirect_seq against a memory-level reference model.
module tb_mem_indirect_seq;
    logic        iClk = 0, iRstN = 0;
    logic        iMemRead = 0, iMemWrite = 0, iIndirect = 0, iByte = 0;
    logic [15:0] iAddr = 0, iWData = 0, iDCacheRData = 0;
    logic        iAdvance = 0, iFlush = 0, iDCacheResp = 0;
    logic        oDCacheRead, oDCacheWrite, oIstate;
    logic [15:0] oDCacheAddr, oDCacheWData, oRData;
    logic [1:0]  oDCacheByteEn;
    logic [31:0] oIndirectCount, oWaitCycles;
    int          checks = 0, errors = 0, ind_cnt = 0, wait_cnt = 0;
    logic [15:0] mem [logic [15:0]];

    mem_indirect_seq dut (
        .iClk(iClk), .iRstN(iRstN), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iIndirect(iIndirect), .iByte(iByte), .iAddr(iAddr), .iWData(iWData),
        .iAdvance(iAdvance), .iFlush(iFlush), .oDCacheRead(oDCacheRead),
        .oDCacheWrite(oDCacheWrite), .oDCacheAddr(oDCacheAddr), .oDCacheWData(oDCacheWData),
        .oDCacheByteEn(oDCacheByteEn), .iDCacheRData(iDCacheRData), .iDCacheResp(iDCacheResp),
        .oIstate(oIstate), .oRData(oRData), .oIndirectCount(oIndirectCount),
        .oWaitCycles(oWaitCycles)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mrd(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    task automatic mwr(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] w;
        w = mrd(a);
        if (be[1]) w[15:8] = d[15:8];
        if (be[0]) w[7:0] = d[7:0];
        mem[a] = w;
    endtask

    task automatic next_edge;
        @(posedge iClk);
        #1;
    endtask

    task automatic idle;
        iMemRead = 0; iMemWrite = 0; iIndirect = 0; iByte = 0;
        iAdvance = 0; iFlush = 0; iDCacheResp = 0;
    endtask

    task automatic check_req(input string tag, input bit erd, input bit ewr,
                             input logic [15:0] ea, input logic [1:0] eb, input logic [15:0] ew);
        check({tag, ".rd"}, 32'(oDCacheRead), 32'(erd));
        check({tag, ".wr"}, 32'(oDCacheWrite), 32'(ewr));
        check({tag, ".addr"}, 32'(oDCacheAddr), 32'(ea));
        if (ewr) begin
            check({tag, ".be"}, 32'(oDCacheByteEn), 32'(eb));
            check({tag, ".wdata"}, 32'(oDCacheWData), 32'(ew));
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef MEM_INDIRECT_STATS_EN
        check({tag, ".icnt"}, oIndirectCount, 32'(ind_cnt));
        check({tag, ".wcnt"}, oWaitCycles, 32'(wait_cnt));
`else
        check({tag, ".icnt"}, oIndirectCount, 32'd0);
        check({tag, ".wcnt"}, oWaitCycles, 32'd0);
`endif
    endtask

    // One complete MEM-stage instruction; the bench plays the D-cache from its memory model.
    task automatic access(input bit ld, input bit ind, input bit byt, input logic [15:0] a,
                          input logic [15:0] wd, input int lat1, input int lat2, input bit hold);
        logic [15:0] ea, ew, d, p;
        logic [1:0]  eb;
        ea = ind ? {a[15:1], 1'b0} : (byt ? a : {a[15:1], 1'b0});
        eb = (ind || !byt) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        ew = (ind || !byt) ? wd : {wd[7:0], wd[7:0]};
        iMemRead = ld; iMemWrite = !ld; iIndirect = ind; iByte = byt;
        iAddr = a; iWData = wd; iAdvance = 0; iDCacheResp = 0;
        for (int i = 0; i < lat1; i++) begin
            @(negedge iClk);
            check_req("wait0", ind || ld, !ind && !ld, ea, eb, ew);
            wait_cnt++;
            next_edge();
        end
        d = (ind || ld) ? mrd({ea[15:1], 1'b0}) : 16'($urandom);
        iDCacheResp = 1; iDCacheRData = d; iAdvance = !ind;
        @(negedge iClk);
        check_req("resp0", ind || ld, !ind && !ld, ea, eb, ew);
        if (!ind && ld) check("rdata0", 32'(oRData), 32'(byt ? {8'h00, a[0] ? d[15:8] : d[7:0]} : d));
        if (!ind && !ld) mwr({ea[15:1], 1'b0}, eb, ew);
        next_edge();
        iDCacheResp = 0; iAdvance = 0;
        if (ind) begin
            check("istate_up", 32'(oIstate), 32'd1);
            p = {d[15:1], 1'b0};
            for (int i = 0; i < lat2; i++) begin
                @(negedge iClk);
                check_req("wait1", ld, !ld, p, 2'b11, wd);
                wait_cnt++;
                next_edge();
            end
            d = ld ? mrd(p) : 16'($urandom);
            iDCacheResp = 1; iDCacheRData = d; iAdvance = !hold;
            @(negedge iClk);
            check_req("resp1", ld, !ld, p, 2'b11, wd);
            if (ld) check("rdata1", 32'(oRData), 32'(d));
            if (!ld) mwr(p, 2'b11, wd);
            next_edge();
            iDCacheResp = 0; iDCacheRData = 16'($urandom);
            if (hold) begin
                iAdvance = 1;
                @(negedge iClk);
                check("hold.istate", 32'(oIstate), 32'd1);
                check("hold.strobe", 32'({oDCacheRead, oDCacheWrite}), 32'd0);
                if (ld) check("hold.rdata", 32'(oRData), 32'(d));
                next_edge();
            end
            ind_cnt++;
        end
        idle();
        check("istate_end", 32'(oIstate), 32'd0);
        check_cnt("acc");
    endtask

    initial begin
        idle();
        #2;
        check("rst.istate", 32'(oIstate), 32'd0);
        check("rst.strobe", 32'({oDCacheRead, oDCacheWrite}), 32'd0);
        check("rst.rdata", 32'(oRData), 32'd0);
        check_cnt("rst");
        next_edge();
        iRstN = 1;
        next_edge();
        // Directed scenarios
        mem[16'h3000] = 16'hBEEF;
        access(1, 0, 0, 16'h3001, 16'h0, 2, 0, 0);
        mem[16'h4000] = 16'h5002; mem[16'h5002] = 16'h1234;
        access(1, 1, 0, 16'h4000, 16'h0, 0, 1, 0);
        mem[16'h4000] = 16'h6000;
        access(0, 1, 0, 16'h4000, 16'hA5A5, 1, 0, 0);
        check("sti.mem", 32'(mem[16'h6000]), 32'h0000A5A5);
        access(0, 0, 1, 16'h2003, 16'h00CD, 0, 0, 0);
        mem[16'h2002] = 16'hCD11;
        access(1, 0, 1, 16'h2003, 16'h0, 1, 0, 0);
        mem[16'h7000] = 16'h7100; mem[16'h7100] = 16'h4242;
        access(1, 1, 0, 16'h7000, 16'h0, 0, 2, 1);
        // LDI squashed on its first response
        iMemRead = 1; iIndirect = 1; iAddr = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            check("flush.wait", 32'(oDCacheRead), 32'd1);
            wait_cnt++;
            next_edge();
        end
        iDCacheResp = 1; iDCacheRData = 16'h5002; iFlush = 1;
        next_edge();
        idle();
        check("flush.istate", 32'(oIstate), 32'd0);
        check_cnt("flush");
        // Random mix against the memory model
        for (int n = 0; n < 60; n++) begin
            bit ind;
            ind = ($urandom_range(0, 2) == 0);
            access(1'($urandom), ind, !ind && 1'($urandom), 16'h8000 | 16'($urandom_range(0, 31)),
                   16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   ind && ($urandom_range(0, 3) == 0));
        end
        // Asynchronous reset in the middle of a data phase
        iMemRead = 1; iIndirect = 1; iAddr = 16'h4000;
        iDCacheResp = 1; iDCacheRData = 16'h5002;
        next_edge();
        iDCacheResp = 0;
        check("mid.istate", 32'(oIstate), 32'd1);
        iRstN = 0;
        #1;
        check("mid.rst.istate", 32'(oIstate), 32'd0);
        check("mid.rst.strobe", 32'({oDCacheRead, oDCacheWrite}), 32'd0);
        check("mid.rst.rdata", 32'(oRData), 32'd0);
        ind_cnt = 0; wait_cnt = 0;
        check_cnt("mid.rst");
        next_edge();
        idle();
        iRstN = 1;
        next_edge();
        check("post.istate", 32'(oIstate), 32'd0);
        access(1, 1, 0, 16'h4000, 16'h0, 1, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_indirect_seq.md
# mem_indirect_seq

Memory-stage access sequencer for the LC-3b pipeline. It sits between the EX/MEM pipeline register and the D-cache and drives every data-cache request. It runs LDI/STI as a two-phase pointer-then-data sequence and exports the indirect phase bit (istate) that the stall logic uses to hold the pipeline. It also handles LDB/STB byte lanes and word alignment.

## Interface
- No parameters; datapath width fixed at 16 bits (lc3b_word).
- iClk  in  1  pipeline clock; all state updates on posedge.
- iRstN  in  1  asynchronous active-low reset.
- iMemRead  in  1  MEM-stage instruction reads memory (LDR/LDB/LDI).
- iMemWrite  in  1  MEM-stage instruction writes memory (STR/STB/STI).
- iIndirect  in  1  instruction is LDI/STI.
- iByte  in  1  byte access (LDB/STB).
- iAddr  in  16  effective address from EX/MEM.
- iWData  in  16  store data from EX/MEM.
- iAdvance  in  1  MEM stage hands off to MEM/WB this cycle (pipeline not stalled).
- iFlush  in  1  MEM stage is squashed (PC-change flush).
- oDCacheRead  out  1  D-cache read strobe, held until iDCacheResp.
- oDCacheWrite  out  1  D-cache write strobe, held until iDCacheResp.
- oDCacheAddr  out  16  D-cache address.
- oDCacheWData  out  16  D-cache write data.
- oDCacheByteEn  out  2  write byte enables.
- iDCacheRData  in  16  D-cache read data.
- iDCacheResp  in  1  D-cache completion, one cycle per request.
- oIstate  out  1  0 = pointer phase (or non-indirect), 1 = data phase.
- oRData  out  16  load result to MEM/WB; byte loads are zero-extended.
- oIndirectCount  out  32  completed LDI/STI count (see Configuration).
- oWaitCycles  out  32  cycles with an outstanding D-cache request (see Configuration).

## Operation
- Two states: PHASE0 (oIstate=0) and PHASE1 (oIstate=1). Pointer register ptr[15:0].
- Active access: act = iMemRead | iMemWrite. When act=0, all strobes are 0.
- Non-indirect access in PHASE0:
  - oDCacheRead = iMemRead and oDCacheWrite = iMemWrite.
  - Word access: address {iAddr[15:1],1'b0}, ByteEn 2'b11, WData iWData.
  - Byte access: address iAddr; ByteEn 2'b10 if iAddr[0] else 2'b01; WData {iWData[7:0],iWData[7:0]}.
- Indirect access in PHASE0:
  - Always a word read at {iAddr[15:1],0}, including for STI.
  - On iDCacheResp: ptr <= iDCacheRData and the state moves to PHASE1. iAdvance is ignored in this phase because the stall logic holds the pipeline.
- PHASE1:
  - The access uses ptr (bit 0 forced to 0) as a word access: read for LDI, write of iWData for STI.
  - On iDCacheResp & iAdvance the state returns to PHASE0.
  - On iDCacheResp without iAdvance the state stays in PHASE1 and no new request is issued: strobes drop and the read data is held in rdata_q.
- oRData:
  - Word: iDCacheRData on the response cycle, otherwise rdata_q.
  - Byte: {8'h00, selected byte}, with iAddr[0] selecting the high byte.
- iFlush has the highest priority. It forces PHASE0 next cycle, clears the held-response flag, and blocks counter increments that cycle.
- Reset: state=PHASE0, ptr=0, rdata_q=0, counters=0. All outputs are 0 while iRstN=0.

## Timing
- Strobes, address, data and ByteEn are combinational from state, ptr and the MEM inputs, and stay stable until iDCacheResp.
- A cache hit with single-cycle resp gives:
  - non-indirect access: 1 cycle;
  - LDI/STI: at least 2 cycles, with oIstate rising on the cycle after the first resp.
- iDCacheResp while act=0 is ignored.
- If iRstN is asserted mid-sequence, the state returns to PHASE0 immediately and asynchronously. An outstanding request is abandoned and strobes deassert.
- iFlush in the same cycle as iDCacheResp in PHASE0: the flush wins and the state stays PHASE0.

## Configuration
- MEM_INDIRECT_STATS_EN defined:
  - oIndirectCount increments on each PHASE1 completion (resp & iAdvance & ~iFlush).
  - oWaitCycles increments on every cycle with a strobe high and iDCacheResp=0.
  - Both counters are 32-bit and wrap.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset with iRstN=0 mid-PHASE1 -> oIstate=0, strobes=0, oRData=0 in the same cycle.
- LDR iAddr=16'h3001, cache resp after 2 cycles with data 16'hBEEF -> oDCacheAddr=16'h3000 and oRData=16'hBEEF on the resp cycle.
- LDI iAddr=16'h4000: mem[4000]=16'h5002, mem[5002]=16'h1234 -> first read at 16'h4000, oIstate=1 next cycle, second read at 16'h5002, oRData=16'h1234, then oIstate=0 after iAdvance.
- STI iAddr=16'h4000, mem[4000]=16'h6000, iWData=16'hA5A5 -> a read at 16'h4000, then a write at 16'h6000 with ByteEn=2'b11 and WData=16'hA5A5.
- STB iAddr=16'h2003, iWData=16'h00CD -> ByteEn=2'b10 and WData=16'hCDCD. LDB at 16'h2003 returning 16'hCD11 -> oRData=16'h00CD.
- LDI with iFlush asserted on the first resp -> oIstate stays 0. With MEM_INDIRECT_STATS_EN, oIndirectCount is unchanged and oWaitCycles equals the number of stalled cycles.
